scan_chain_ctrl: RTL and testbench

//  Drives one scan chain built from scan flops (D/SE/SI/CK, Q->next SI).

---
 rtl/scan_ctrl_pkg.sv | 7 +
 rtl/scan_shreg.sv | 19 +
 rtl/scan_chain_ctrl.sv | 124 ++++++++++++
 tb/tb_scan_chain_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/scan_ctrl_pkg.sv
// scan_ctrl_pkg: shared state encoding and sizing helper for the scan chain controller.
package scan_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, SHIFT, CAPT, WAIT, FLUSH} scan_state_t;
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/scan_shreg.sv
// scan_shreg: shift register with parallel load, serial input into the MSB and shift towards bit 0.
module scan_shreg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_data_i,
  input  logic         shift_i,
  input  logic         si_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= '0;
    else if (load_i) q_q <= load_data_i;
    else if (shift_i) q_q <= {si_i, q_q[W-1:1]};
  assign q_o = q_q;
endmodule

// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: loads patterns onto a scan chain, captures, and unloads responses overlapped with the next load.
// Optional response compare against an expected word is built when SCAN_CHAIN_COMPARE_EN is defined.
module scan_chain_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN      = 16,
  parameter int CAPTURE_CYCLES = 1
) (
  input  logic                 CK,
  input  logic                 RN,
  input  logic                 pat_valid,
  output logic                 pat_ready,
  input  logic [CHAIN_LEN-1:0] pat_data,
`ifdef SCAN_CHAIN_COMPARE_EN
  input  logic [CHAIN_LEN-1:0] pat_exp,
  output logic                 rsp_mismatch,
`endif
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CHAIN_LEN-1:0] rsp_data,
  output logic                 scan_se,
  output logic                 scan_si,
  input  logic                 scan_so,
  output logic                 chain_ck_en,
  output logic                 busy
);
  localparam int CW = cnt_width(CHAIN_LEN);
  localparam logic [CW-1:0] LAST_SHIFT = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] LAST_CAPT  = CW'(CAPTURE_CYCLES - 1);

  scan_state_t          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 unload_pend_q, unload_pend_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [CHAIN_LEN-1:0] rsp_data_q, rsp_data_d;
  logic                 scan_se_q, ck_en_q, busy_q, ready_q;
  logic [CHAIN_LEN-1:0] load_q, unload_q;
  logic                 slot_free, accept, unload_shift, publish, last_shift, last_capt;
  logic                 unused_bits;

  assign slot_free    = !rsp_valid_q || rsp_ready;
  assign last_shift   = cnt_q == LAST_SHIFT;
  assign last_capt    = cnt_q == LAST_CAPT;
  // IDLE never unloads, so it may accept even while a response is still held
  assign pat_ready    = ready_q && (state_q == IDLE || slot_free);
  assign accept       = pat_valid && pat_ready;
  assign unload_shift = (state_q == SHIFT && unload_pend_q) || state_q == FLUSH;
  assign publish      = unload_shift && last_shift;
  assign unused_bits  = ^{load_q[CHAIN_LEN-1:1], unload_q[0]};

  scan_shreg #(.W(CHAIN_LEN)) u_load_sr (
    .clk(CK), .rst_n(RN), .load_i(accept), .load_data_i(pat_data),
    .shift_i(state_q == SHIFT), .si_i(1'b0), .q_o(load_q)
  );

  scan_shreg #(.W(CHAIN_LEN)) u_unload_sr (
    .clk(CK), .rst_n(RN), .load_i(1'b0), .load_data_i('0),
    .shift_i(unload_shift), .si_i(scan_so), .q_o(unload_q)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? SHIFT : IDLE;
      SHIFT:   state_d = last_shift ? CAPT : SHIFT;
      CAPT:    state_d = !last_capt ? CAPT : accept ? SHIFT : slot_free ? FLUSH : WAIT;
      WAIT:    state_d = accept ? SHIFT : slot_free ? FLUSH : WAIT;
      FLUSH:   state_d = last_shift ? IDLE : FLUSH;
      default: state_d = IDLE;
    endcase
    cnt_d         = (state_d != state_q) ? '0 : cnt_q + 1'b1;
    unload_pend_d = (state_q == CAPT && last_capt) ? 1'b1 :
                    (state_q == FLUSH && last_shift) ? 1'b0 : unload_pend_q;
    rsp_valid_d   = publish ? 1'b1 : rsp_ready ? 1'b0 : rsp_valid_q;
    rsp_data_d    = publish ? {scan_so, unload_q[CHAIN_LEN-1:1]} : rsp_data_q;
  end

  always_ff @(posedge CK or negedge RN)
    if (!RN) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      unload_pend_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      scan_se_q     <= 1'b0;
      ck_en_q       <= 1'b0;
      busy_q        <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      unload_pend_q <= unload_pend_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      scan_se_q     <= state_d == SHIFT || state_d == FLUSH;
      ck_en_q       <= state_d inside {SHIFT, CAPT, FLUSH};
      busy_q        <= state_d != IDLE;
      ready_q       <= state_d == IDLE || state_d == WAIT || (state_d == CAPT && cnt_d == LAST_CAPT);
    end

`ifdef SCAN_CHAIN_COMPARE_EN
  logic [CHAIN_LEN-1:0] exp_load_q, exp_unl_q;
  logic                 mismatch_q;
  // expected word follows its pattern into the unload slot when capture completes
  always_ff @(posedge CK or negedge RN)
    if (!RN) begin
      exp_load_q <= '0;
      exp_unl_q  <= '0;
      mismatch_q <= 1'b0;
    end else begin
      if (accept) exp_load_q <= pat_exp;
      if (state_q == CAPT && last_capt) exp_unl_q <= exp_load_q;
      if (publish) mismatch_q <= |(rsp_data_d ^ exp_unl_q);
    end
  assign rsp_mismatch = mismatch_q;
`endif

  assign scan_si     = state_q == SHIFT && load_q[0];
  assign scan_se     = scan_se_q;
  assign chain_ck_en = ck_en_q;
  assign busy        = busy_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb_scan_chain_ctrl: directed bench with a 16-flop chain model (hold or invert on capture).
module tb_scan_chain_ctrl;
  logic        CK, RN, pat_valid, pat_ready, rsp_valid, rsp_ready;
  logic [15:0] pat_data, rsp_data;
  logic        scan_se, scan_si, scan_so, chain_ck_en, busy;
`ifdef SCAN_CHAIN_COMPARE_EN
  logic [15:0] pat_exp;
  logic        rsp_mismatch;
`endif
  logic [15:0] chain;
  logic        inv_capt;
  logic [15:0] rq[$];
  logic [15:0] pats[4];
  int npat, pi, run, maxrun, checks, errors, n;

  scan_chain_ctrl dut (
    .CK(CK), .RN(RN), .pat_valid(pat_valid), .pat_ready(pat_ready), .pat_data(pat_data),
`ifdef SCAN_CHAIN_COMPARE_EN
    .pat_exp(pat_exp), .rsp_mismatch(rsp_mismatch),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .scan_se(scan_se), .scan_si(scan_si), .scan_so(scan_so),
    .chain_ck_en(chain_ck_en), .busy(busy)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  always @(posedge CK)
    if (chain_ck_en) chain <= scan_se ? {chain[14:0], scan_si} : (inv_capt ? ~chain : chain);
  assign scan_so = chain[15];

  always @(negedge CK)
    if (rsp_valid && rsp_ready) rq.push_back(rsp_data);

  task automatic start_pats(input int cnt);
    npat = cnt; pi = 0; pat_data = pats[0]; pat_valid = 1'b1;
  endtask

  task automatic step();
    logic take;
    @(negedge CK);
    take = pat_valid && pat_ready;
    @(posedge CK);
    #1;
    if (take) begin
      pi++;
      if (pi < npat) pat_data = pats[pi];
      else pat_valid = 1'b0;
    end
    run = chain_ck_en ? run + 1 : 0;
    if (run > maxrun) maxrun = run;
  endtask

  task automatic test_reset();
    RN = 1'b0; pat_valid = 1'b0; pat_data = '0; rsp_ready = 1'b0; inv_capt = 1'b0;
`ifdef SCAN_CHAIN_COMPARE_EN
    pat_exp = '0;
`endif
    repeat (2) @(negedge CK);
    checks++; if (scan_se !== 1'b0) begin errors++; $display("FAIL rst_scan_se got %b want 0", scan_se); end
    checks++; if (scan_si !== 1'b0) begin errors++; $display("FAIL rst_scan_si got %b want 0", scan_si); end
    checks++; if (chain_ck_en !== 1'b0) begin errors++; $display("FAIL rst_ck_en got %b want 0", chain_ck_en); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_data !== 16'h0) begin errors++; $display("FAIL rst_rsp_data got %h want 0000", rsp_data); end
    checks++; if (pat_ready !== 1'b0) begin errors++; $display("FAIL rst_pat_ready got %b want 0", pat_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
`ifdef SCAN_CHAIN_COMPARE_EN
    checks++; if (rsp_mismatch !== 1'b0) begin errors++; $display("FAIL rst_mismatch got %b want 0", rsp_mismatch); end
`endif
    @(posedge CK); #1 RN = 1'b1;
    step();
    checks++; if (pat_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b want 1", pat_ready); end
  endtask

  task automatic test_loopback();
    inv_capt = 1'b0; rsp_ready = 1'b0;
    pats[0] = 16'hA5C3;
`ifdef SCAN_CHAIN_COMPARE_EN
    pat_exp = 16'hA5C3 ^ 16'h0001;
`endif
    start_pats(1);
    n = 0;
    do begin step(); n++; end while (!rsp_valid && n < 100);
    checks++; if (n !== 34) begin errors++; $display("FAIL loop_latency got %0d want 34", n); end
    checks++; if (rsp_data !== 16'hA5C3) begin errors++; $display("FAIL loop_data got %h want a5c3", rsp_data); end
`ifdef SCAN_CHAIN_COMPARE_EN
    checks++; if (rsp_mismatch !== 1'b1) begin errors++; $display("FAIL cmp_diff got %b want 1", rsp_mismatch); end
`endif
    repeat (3) step();
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'hA5C3) begin errors++; $display("FAIL loop_hold got %b/%h want 1/a5c3", rsp_valid, rsp_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL loop_idle got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    pats[0] = 16'h6C6C;
    start_pats(1);
    repeat (6) step();
    checks++; if (scan_se !== 1'b1 || rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_pre got se=%b rv=%b want 1/1", scan_se, rsp_valid); end
    RN = 1'b0;
    #1;
    checks++; if (scan_se !== 1'b0) begin errors++; $display("FAIL mid_scan_se got %b want 0", scan_se); end
    checks++; if (chain_ck_en !== 1'b0) begin errors++; $display("FAIL mid_ck_en got %b want 0", chain_ck_en); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_valid got %b want 0", rsp_valid); end
    @(negedge CK) RN = 1'b1;
    step();
    checks++; if (busy !== 1'b0 || pat_ready !== 1'b1) begin errors++; $display("FAIL mid_release got busy=%b ready=%b want 0/1", busy, pat_ready); end
  endtask

  task automatic test_invert();
    logic [15:0] pv[2], ev[2];
    pv[0] = 16'h0000; ev[0] = 16'hFFFF;
    pv[1] = 16'h00FF; ev[1] = 16'hFF00;
    inv_capt = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pats[0] = pv[i];
`ifdef SCAN_CHAIN_COMPARE_EN
      pat_exp = pv[i];
`endif
      start_pats(1);
      n = 0;
      do begin step(); n++; end while (!rsp_valid && n < 100);
      checks++; if (rsp_data !== ev[i]) begin errors++; $display("FAIL inv_data%0d got %h want %h", i, rsp_data, ev[i]); end
      while (busy && n < 200) begin step(); n++; end
    end
  endtask

`ifdef SCAN_CHAIN_COMPARE_EN
  task automatic test_compare();
    inv_capt = 1'b0; rsp_ready = 1'b1;
    pats[0] = 16'h5AA5; pat_exp = 16'h5AA5;
    start_pats(1);
    n = 0;
    do begin step(); n++; end while (!rsp_valid && n < 100);
    checks++; if (rsp_mismatch !== 1'b0) begin errors++; $display("FAIL cmp_equal got %b want 0", rsp_mismatch); end
    while (busy && n < 200) begin step(); n++; end
  endtask
`endif

  task automatic test_back_to_back();
    inv_capt = 1'b0; rsp_ready = 1'b1;
    step();
    rq.delete(); run = 0; maxrun = 0;
    pats[0] = 16'h1234; pats[1] = 16'hBEEF;
    start_pats(2);
    for (int i = 0; i < 70; i++) step();
    checks++; if (pi !== 2) begin errors++; $display("FAIL b2b_accepts got %0d want 2", pi); end
    checks++; if (maxrun !== 50) begin errors++; $display("FAIL b2b_ck_en_run got %0d want 50", maxrun); end
    checks++; if (rq.size() !== 2) begin errors++; $display("FAIL b2b_count got %0d want 2", rq.size()); end
    else begin
      checks++; if (rq[0] !== 16'h1234) begin errors++; $display("FAIL b2b_rsp0 got %h want 1234", rq[0]); end
      checks++; if (rq[1] !== 16'hBEEF) begin errors++; $display("FAIL b2b_rsp1 got %h want beef", rq[1]); end
    end
  endtask

  task automatic test_stall();
    inv_capt = 1'b0; rsp_ready = 1'b0;
    rq.delete();
    pats[0] = 16'h0F0F; pats[1] = 16'h3C3C; pats[2] = 16'h5A5A;
    start_pats(3);
    n = 0;
    do begin step(); n++; end while (!(rsp_valid && busy && !chain_ck_en) && n < 100);
    checks++; if (n >= 100) begin errors++; $display("FAIL stall_wait_entry got timeout want WAIT"); end
    checks++; if (rsp_data !== 16'h0F0F) begin errors++; $display("FAIL stall_data0 got %h want 0f0f", rsp_data); end
    repeat (4) step();
    checks++; if (chain_ck_en !== 1'b0 || scan_se !== 1'b0) begin errors++; $display("FAIL stall_frozen got ck=%b se=%b want 0/0", chain_ck_en, scan_se); end
    checks++; if (pat_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %b want 0", pat_ready); end
    checks++; if (rsp_data !== 16'h0F0F || pi !== 2) begin errors++; $display("FAIL stall_stable got %h/%0d want 0f0f/2", rsp_data, pi); end
    rsp_ready = 1'b1;
    n = 0;
    do begin step(); n++; end while (busy && n < 200);
    step();
    checks++; if (pi !== 3) begin errors++; $display("FAIL stall_accepts got %0d want 3", pi); end
    checks++; if (rq.size() !== 3) begin errors++; $display("FAIL stall_count got %0d want 3", rq.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++; if (rq[i] !== pats[i]) begin errors++; $display("FAIL stall_rsp%0d got %h want %h", i, rq[i], pats[i]); end
    end
  endtask

  initial begin
    checks = 0; errors = 0; run = 0; maxrun = 0;
    test_reset();
    test_loopback();
    test_reset_mid();
    test_invert();
`ifdef SCAN_CHAIN_COMPARE_EN
    test_compare();
`endif
    test_back_to_back();
    test_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
